// File: rtl/multicycle_control_fsm_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the 16-bit datapath.
// The slave side is the sequencer; the master side is the datapath/memory environment.
interface multicycle_control_fsm_if;
    logic        run;
    logic [3:0]  opcode;
    logic        instr_ready;
    logic        data_ready;
    logic        instr_req;
    logic        ir_write;
    logic        pc_write;
    logic        branch;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        shift;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  alu_op;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [3:0]  state;
    logic [15:0] instr_count;

    modport master (
        output run, opcode, instr_ready, data_ready,
        input  instr_req, ir_write, pc_write, branch, reg_dst, alu_src, mem_to_reg,
               shift, reg_write, mem_read, mem_write, alu_op, trap, trap_cause,
               state, instr_count
    );

    modport slave (
        input  run, opcode, instr_ready, data_ready,
        output instr_req, ir_write, pc_write, branch, reg_dst, alu_src, mem_to_reg,
               shift, reg_write, mem_read, mem_write, alu_op, trap, trap_cause,
               state, instr_count
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the 16-bit datapath: fetch/decode/execute/memory/writeback
// with ready handshakes on both memories, a wait timeout and a sticky trap.
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT       = 15,
    parameter logic [15:0] INSTR_COUNT_RESET = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_control_fsm_if.slave bus
);
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_WB_I     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_WB_MEM   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_TRAP     = 4'd15
    } state_e;

    typedef struct packed {
        logic       instr_req;
        logic       branch;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       shift;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [7:0] TIMEOUT       = 8'(MEM_TIMEOUT);
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_FETCH   = 2'b10;
    localparam logic [1:0] CAUSE_DATA    = 2'b11;

    state_e      state_q, state_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic        trap_q, trap_d;
    logic [1:0]  trap_cause_q, trap_cause_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic        retire_s;
    logic        timeout_s;
    logic        waiting_s;
    logic        fetch_load_s;

    function automatic ctrl_t decode_ctrl(input state_e st, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: c.instr_req = 1'b1;
            ST_EXEC_R, ST_WB_R: begin
                c.alu_op    = 2'b10;
                c.reg_dst   = 1'b1;
                c.shift     = (op == 4'b0010);
                c.reg_write = (st == ST_WB_R);
            end
            ST_EXEC_I, ST_WB_I: begin
                c.alu_op    = 2'b11;
                c.alu_src   = 1'b1;
                c.reg_write = (st == ST_WB_I);
            end
            ST_MEM_ADDR: c.alu_src = 1'b1;
            ST_MEM_RD: begin
                c.alu_src  = 1'b1;
                c.mem_read = 1'b1;
            end
            ST_MEM_WR: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            ST_WB_MEM: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_op = 2'b01;
                c.branch = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign timeout_s = (wait_q == TIMEOUT);
    assign waiting_s = ((state_q == ST_FETCH) && !bus.instr_ready) ||
                       (((state_q == ST_MEM_RD) || (state_q == ST_MEM_WR)) && !bus.data_ready);

    // Next-state, retire, wait-counter and trap bookkeeping.
    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        retire_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_FETCH;
                else         state_d = ST_IDLE;
            end
            ST_FETCH: begin
                // A ready arriving on the timeout cycle still wins.
                if (bus.instr_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout_s) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (bus.opcode)
                    4'b0000, 4'b0001, 4'b0010: state_d = ST_EXEC_R;
                    4'b1001, 4'b1010, 4'b1011: state_d = ST_EXEC_I;
                    4'b1100, 4'b1101:          state_d = ST_MEM_ADDR;
                    4'b1111:                   state_d = ST_BRANCH;
                    default: begin
                        state_d      = ST_TRAP;
                        trap_cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_EXEC_I:   state_d = ST_WB_I;
            ST_MEM_ADDR: begin
                if (bus.opcode[0]) state_d = ST_MEM_WR;
                else               state_d = ST_MEM_RD;
            end
            ST_MEM_RD: begin
                if (bus.data_ready) begin
                    state_d = ST_WB_MEM;
                end else if (timeout_s) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_DATA;
                end else begin
                    state_d = ST_MEM_RD;
                end
            end
            ST_MEM_WR: begin
                if (bus.data_ready) begin
                    retire_s = 1'b1;
                end else if (timeout_s) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_DATA;
                end else begin
                    state_d = ST_MEM_WR;
                end
            end
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH: retire_s = 1'b1;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase

        if (retire_s) begin
            instr_count_d = instr_count_q + 16'd1;
            state_d       = bus.run ? ST_FETCH : ST_IDLE;
        end else begin
            instr_count_d = instr_count_q;
        end

        if (state_d != state_q) wait_d = 8'd0;
        else if (waiting_s)     wait_d = wait_q + 8'd1;
        else                    wait_d = wait_q;

        trap_d = trap_q | (state_d == ST_TRAP);
        ctrl_d = decode_ctrl(state_d, bus.opcode);
    end

    // State and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ctrl_q        <= '0;
            trap_q        <= 1'b0;
            trap_cause_q  <= 2'b00;
            wait_q        <= 8'd0;
            instr_count_q <= INSTR_COUNT_RESET;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            trap_q        <= trap_d;
            trap_cause_q  <= trap_cause_d;
            wait_q        <= wait_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Architectural write strobes are forced low while reset is asserted.
    assign fetch_load_s    = (state_q == ST_FETCH) && bus.instr_ready && !rst;
    assign bus.ir_write    = fetch_load_s;
    assign bus.pc_write    = fetch_load_s;
    assign bus.reg_write   = ctrl_q.reg_write & ~rst;
    assign bus.mem_write   = ctrl_q.mem_write & ~rst;
    assign bus.instr_req   = ctrl_q.instr_req;
    assign bus.branch      = ctrl_q.branch;
    assign bus.reg_dst     = ctrl_q.reg_dst;
    assign bus.alu_src     = ctrl_q.alu_src;
    assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
    assign bus.shift       = ctrl_q.shift;
    assign bus.mem_read    = ctrl_q.mem_read;
    assign bus.alu_op      = ctrl_q.alu_op;
    assign bus.trap        = trap_q;
    assign bus.trap_cause  = trap_cause_q;
    assign bus.state       = state_q;
    assign bus.instr_count = instr_count_q;
endmodule
